// File: rtl/store_drain_buffer_pkg.sv
// Shared types for the retired-store drain buffer: the LSQ entry seen at
// retire, the buffered store record, memory-type codes and the byte-lane
// alignment helper used when a store enters the buffer.
package store_drain_buffer_pkg;

  localparam int XLEN  = 64;
  localparam int LANES = XLEN / 8;

  // Memory access size codes carried in the LSQ entry.
  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;
  localparam logic [1:0] SD = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] data;
    logic [1:0]      mem_type;
  } lsq_entry;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [LANES-1:0] be;
  } store_buf_entry;

  typedef enum logic {IDLE, REQ} drain_state_e;

  // Move a store onto its byte lanes within the 8-byte word. Enables past
  // lane 7 are dropped, so a boundary-crossing store is truncated.
  function automatic store_buf_entry align_store(input logic [XLEN-1:0] address,
                                                 input logic [XLEN-1:0] data,
                                                 input int size);
    store_buf_entry e;
    logic [2*LANES-1:0] mask;
    mask   = (16'(1) << size) - 16'd1;
    mask   = mask << address[2:0];
    e.addr = {address[XLEN-1:3], 3'b000};
    e.be   = mask[LANES-1:0];
    e.data = data << {address[2:0], 3'b000};
    return e;
  endfunction

  // True when a store of this size starting at this offset spills past lane 7.
  function automatic logic store_crosses(input logic [2:0] offset, input int size);
    return (int'(offset) + size) > LANES;
  endfunction

endpackage

// File: rtl/store_drain_buffer_if.sv
// Data-memory write port: a request held stable until the memory acks it.
interface store_drain_buffer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [7:0]        mem_be;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, mem_data, mem_be, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_data, mem_be, output mem_ack);
endinterface

// File: rtl/store_drain_buffer_fwd.sv
// store_fwd_match: searches buffered stores for one that fully covers a
// load's bytes at the same 8-byte word; the youngest such store wins.
module store_fwd_match
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  store_buf_entry [DEPTH-1:0]   ents,
  input  logic [DEPTH-1:0]             vld,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [XLEN-1:0]              probe_addr,
  input  logic [LANES-1:0]             probe_be,
  output logic                         hit,
  output logic [XLEN-1:0]              data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign match[i] = vld[i] && (ents[i].addr == probe_addr) &&
                      ((ents[i].be & probe_be) == probe_be);
  end

  // Walk oldest to youngest so a younger match overrides an older one.
  always_comb begin
    logic [PTR_W-1:0] slot;
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if (match[slot]) begin
        hit  = 1'b1;
        data = ents[slot].data;
      end
    end
  end
endmodule

// File: rtl/store_drain_buffer.sv
// store_drain_buffer: in-order FIFO of retired stores drained to the data
// memory one write per ack. The in-flight store stays in the FIFO until it
// is acked, so count and forwarding both include it.
// Optional store-to-load forwarding is built when STORE_FWD_EN is defined;
// otherwise ld_hit/ld_data are tied low.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_push,
  input  lsq_entry                   le,
  input  int                         le_size,
  output logic                       retire_stall,
  store_drain_buffer_if.master       mem,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [7:0]                 ld_be,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  store_buf_entry [DEPTH-1:0] sb_mem;
  store_buf_entry             push_ent, head_q, head_nxt;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           cnt_q;
  drain_state_e               state, state_nxt;
  logic                       req_q, req_nxt;
  logic                       full, push, pop;

  assign push_ent = align_store(le.address, le.data, le_size);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign push     = st_push && (le_size != 0) && !full;
  assign pop      = (state == REQ) && mem.mem_ack;

  // Drain FSM: choose the next store to present. A push into an empty
  // buffer bypasses straight to the request registers, and when the only
  // buffered store is acked alongside a push the new store follows at once.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    head_nxt  = head_q;
    case (state)
      IDLE: begin
        if (cnt_q != '0) begin
          head_nxt  = sb_mem[rd_ptr];
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end else if (push) begin
          head_nxt  = push_ent;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (pop) begin
          if (cnt_q > CNT_W'(1)) begin
            head_nxt = sb_mem[rd_ptr + PTR_W'(1)];
          end else if (push) begin
            head_nxt = push_ent;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  // FSM state and the registered memory request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      head_q <= '0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_nxt;
      head_q <= head_nxt;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Store payload array; slots are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) sb_mem[wr_ptr] <= push_ent;
  end

  // Flag retire-side misuse in simulation; the hardware drops or truncates.
  always @(posedge clk) begin
    if (reset && st_push && (le_size != 0)) begin
      assert (!full)
        else $warning("store_drain_buffer: push while full dropped");
      assert (!store_crosses(le.address[2:0], le_size))
        else $warning("store_drain_buffer: store crosses 8-byte boundary, upper bytes truncated");
      assert (le_size == (1 << le.mem_type))
        else $warning("store_drain_buffer: le_size disagrees with mem_type");
    end
  end

  assign retire_stall  = full;
  assign count         = cnt_q;
  assign empty         = (cnt_q == '0);
  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = head_q.addr[ADDR_W-1:0];
  assign mem.mem_data  = head_q.data[DATA_W-1:0];
  assign mem.mem_be    = head_q.be;

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0] slot_vld;
  logic [XLEN-1:0]  fwd_data;
  logic             fwd_hit;
  logic             unused_ld_lo;

  // A slot is live when its age behind the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PTR_W-1:0] age;
    assign age         = PTR_W'(i) - rd_ptr;
    assign slot_vld[i] = CNT_W'(age) < cnt_q;
  end

  store_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .ents       (sb_mem),
    .vld        (slot_vld),
    .rd_ptr     (rd_ptr),
    .probe_addr (XLEN'({ld_addr[ADDR_W-1:3], 3'b000})),
    .probe_be   (ld_be),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );

  assign ld_hit       = fwd_hit;
  assign ld_data      = fwd_data[DATA_W-1:0];
  assign unused_ld_lo = ^ld_addr[2:0];
`else
  logic unused_ld;
  assign ld_hit    = 1'b0;
  assign ld_data   = '0;
  assign unused_ld = ^{ld_addr, ld_be};
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: a vector table for the drain
// stream and fill/back-pressure behaviour, plus hand sequences for the
// single store, asynchronous reset and forwarding cases.
module tb_store_drain_buffer;
  import store_drain_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_push;
  lsq_entry    le;
  int          le_size;
  logic        retire_stall;
  logic [2:0]  count;
  logic        empty;
  logic [63:0] ld_addr;
  logic [7:0]  ld_be;
  logic        ld_hit;
  logic [63:0] ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  store_drain_buffer_if #(.ADDR_W(64), .DATA_W(64)) mif ();

  store_drain_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_push      (st_push),
    .le           (le),
    .le_size      (le_size),
    .retire_stall (retire_stall),
    .mem          (mif),
    .count        (count),
    .empty        (empty),
    .ld_addr      (ld_addr),
    .ld_be        (ld_be),
    .ld_hit       (ld_hit),
    .ld_data      (ld_data)
  );

  always #5 clk = ~clk;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        push;
    int          size;
    logic [1:0]  mt;
    logic [63:0] addr;
    logic [63:0] data;
    logic        ack;
    int          cnt;
    logic        req;
    logic [63:0] eaddr;
    logic [63:0] edata;
    logic [7:0]  ebe;
    logic        stall;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic p, int sz, logic [1:0] mt, logic [63:0] a, logic [63:0] d,
                              logic ack, int cnt, logic req, logic [63:0] ea, logic [63:0] ed,
                              logic [7:0] eb, logic st);
    vec_t v;
    v.push = p; v.size = sz; v.mt = mt; v.addr = a; v.data = d; v.ack = ack;
    v.cnt = cnt; v.req = req; v.eaddr = ea; v.edata = ed; v.ebe = eb; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input int sz, input logic [1:0] mt,
                       input logic [63:0] a, input logic [63:0] d, input logic ack);
    st_push = p; le_size = sz; le.mem_type = mt; le.address = a; le.data = d;
    mif.mem_ack = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // SB stream with ack held high: one write per cycle, lanes 0..7 in order.
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, 1, SB, 64'(i), 64'h5A, 1, 1, 1, 64'h0, 64'h5A << (8*i), 8'h01 << i, 0);
    vecs[8]  = mk(0, 0, SB, 64'h0,   64'h0,  1, 0, 0, 0, 0, 0, 0);
    // st_push with size 0 is not a store.
    vecs[9]  = mk(1, 0, SB, 64'h200, 64'h33, 0, 0, 0, 0, 0, 0, 0);
    // Fill to DEPTH with ack low, then a dropped push while full.
    vecs[10] = mk(1, 4, SW, 64'h100, 64'h1,  0, 1, 1, 64'h100, 64'h1, 8'h0F, 0);
    vecs[11] = mk(1, 2, SH, 64'h108, 64'h2,  0, 2, 1, 64'h100, 64'h1, 8'h0F, 0);
    vecs[12] = mk(1, 8, SD, 64'h110, 64'h0123456789ABCDEF, 0, 3, 1, 64'h100, 64'h1, 8'h0F, 0);
    vecs[13] = mk(1, 1, SB, 64'h118, 64'h77, 0, 4, 1, 64'h100, 64'h1, 8'h0F, 1);
    vecs[14] = mk(1, 1, SB, 64'h120, 64'h55, 0, 4, 1, 64'h100, 64'h1, 8'h0F, 1);
    // Drain with acks; one simultaneous push/pop; pointers wrap.
    vecs[15] = mk(0, 0, SB, 64'h0,   64'h0,  1, 3, 1, 64'h108, 64'h2, 8'h03, 0);
    vecs[16] = mk(1, 1, SB, 64'h12B, 64'h99, 1, 3, 1, 64'h110, 64'h0123456789ABCDEF, 8'hFF, 0);
    vecs[17] = mk(0, 0, SB, 64'h0,   64'h0,  1, 2, 1, 64'h118, 64'h77, 8'h01, 0);
    vecs[18] = mk(0, 0, SB, 64'h0,   64'h0,  1, 1, 1, 64'h128, 64'h99000000, 8'h08, 0);
    vecs[19] = mk(0, 0, SB, 64'h0,   64'h0,  1, 0, 0, 0, 0, 0, 0);
    // Ack with no request outstanding is ignored.
    vecs[20] = mk(0, 0, SB, 64'h0,   64'h0,  1, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    drive(0, 0, SB, 0, 0, 0);
    ld_addr = '0;
    ld_be   = '0;
    #12;
    chk("reset mem_req",  64'(mif.mem_req),  64'h0);
    chk("reset mem_addr", mif.mem_addr,      64'h0);
    chk("reset mem_data", mif.mem_data,      64'h0);
    chk("reset mem_be",   64'(mif.mem_be),   64'h0);
    chk("reset count",    64'(count),        64'h0);
    chk("reset empty",    64'(empty),        64'h1);
    chk("reset stall",    64'(retire_stall), 64'h0);
    chk("reset ld_hit",   64'(ld_hit),       64'h0);
    chk("reset ld_data",  ld_data,           64'h0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].push, vecs[i].size, vecs[i].mt, vecs[i].addr, vecs[i].data, vecs[i].ack);
      step();
      chk($sformatf("v%0d count", i), 64'(count),        64'(vecs[i].cnt));
      chk($sformatf("v%0d req", i),   64'(mif.mem_req),  64'(vecs[i].req));
      chk($sformatf("v%0d stall", i), 64'(retire_stall), 64'(vecs[i].stall));
      chk($sformatf("v%0d empty", i), 64'(empty),        64'(vecs[i].cnt == 0));
      if (vecs[i].req) begin
        chk($sformatf("v%0d addr", i), mif.mem_addr,    vecs[i].eaddr);
        chk($sformatf("v%0d data", i), mif.mem_data,    vecs[i].edata);
        chk($sformatf("v%0d be", i),   64'(mif.mem_be), 64'(vecs[i].ebe));
      end
    end
    drive(0, 0, SB, 0, 0, 0);
    step();

    // Single SW at 0x1004; req held for two cycles, ack in the second.
    drive(1, 4, SW, 64'h1004, 64'hDEADBEEF, 0);
    step();
    drive(0, 0, SB, 0, 0, 0);
    chk("sw req c1",  64'(mif.mem_req), 64'h1);
    chk("sw addr",    mif.mem_addr,     64'h1000);
    chk("sw be",      64'(mif.mem_be),  64'hF0);
    chk("sw data",    mif.mem_data,     64'hDEADBEEF_00000000);
    step();
    chk("sw req c2",  64'(mif.mem_req), 64'h1);
    chk("sw addr c2", mif.mem_addr,     64'h1000);
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("sw req done", 64'(mif.mem_req), 64'h0);
    chk("sw empty",    64'(empty),       64'h1);

    // Asynchronous reset while a request is outstanding with three stored.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8, SD, 64'h300 + 64'(8*i), 64'hC0 + 64'(i), 0);
      step();
    end
    drive(0, 0, SB, 0, 0, 0);
    chk("pre-rst count", 64'(count),       64'h3);
    chk("pre-rst req",   64'(mif.mem_req), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst req",   64'(mif.mem_req),  64'h0);
    chk("async rst count", 64'(count),        64'h0);
    chk("async rst stall", 64'(retire_stall), 64'h0);
    chk("async rst empty", 64'(empty),        64'h1);
    chk("async rst be",    64'(mif.mem_be),   64'h0);
    #3;
    reset = 1'b1;
    step();

    // Forwarding: SD at 0x40 then SB 0xAA at 0x41; youngest covering store wins.
    drive(1, 8, SD, 64'h40, 64'h88776655_44332211, 0);
    step();
    drive(1, 1, SB, 64'h41, 64'hAA, 0);
    step();
    drive(0, 0, SB, 0, 0, 0);
    ld_addr = 64'h40; ld_be = 8'h02; #1;
    chk("fwd young hit",  64'(ld_hit), 64'(FWD));
    chk("fwd young data", ld_data,     FWD ? 64'h0000_AA00 : 64'h0);
    ld_be = 8'h01; #1;
    chk("fwd old hit",  64'(ld_hit), 64'(FWD));
    chk("fwd old data", ld_data,     FWD ? 64'h88776655_44332211 : 64'h0);
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("fwd pop count", 64'(count), 64'h1);
    ld_be = 8'h06; #1;
    chk("fwd partial hit", 64'(ld_hit), 64'h0);
    ld_be = 8'h02; #1;
    chk("fwd sb hit",  64'(ld_hit), 64'(FWD));
    chk("fwd sb data", ld_data,     FWD ? 64'h0000_AA00 : 64'h0);
    ld_addr = 64'h48; #1;
    chk("fwd other word hit", 64'(ld_hit), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
